// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions used by the transmitter and the
//               receiver: FSM state encoding, default bit timing and frame
//               length constants.
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  // 10 MHz clock / 115200 baud, rounded.
  localparam int UART_DEFAULT_CLK_PER_BIT = 87;

  // Frame lengths in bit times: start + 8 data + stop, optionally + parity.
  localparam int UART_FRAME_BITS     = 10;
  localparam int UART_FRAME_BITS_PAR = 11;

  // State encoding, fixed so the receiver and any debug tooling agree.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } uart_state_e;

  // Whole-frame duration in clock cycles.
  function automatic int uart_frame_cycles(input int clk_per_bit, input bit parity_en);
    return clk_per_bit * (parity_en ? UART_FRAME_BITS_PAR : UART_FRAME_BITS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Byte handshake between a producer and the UART transmitter.
//   tx_data  [7:0] byte to send
//   tx_valid       producer has a byte on tx_data
//   tx_ready       transmitter holding register is empty
// Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_cnt
// Description : Bit-period counter. Counts 0..CLK_PER_BIT-1 and wraps; a
//               synchronous clear holds it at 0.
//   clk        in  clock
//   rst        in  synchronous active-high reset
//   clr_i      in  synchronous clear (held while the line is idle)
//   bit_end_o  out high on the last cycle of a bit period
// Revision    : 1.0  initial release
// ============================================================================
module uart_baud_cnt #(
  parameter int CLK_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int               CW   = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0]    LAST = CW'(CLK_PER_BIT - 1);

  logic [CW-1:0] clk_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      clk_cnt_q <= '0;
    end else if (clk_cnt_q == LAST) begin
      clk_cnt_q <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_q + 1'b1;
    end
  end

  assign bit_end_o = (clk_cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter with a 1-entry holding register. Bytes
//               are accepted on a valid/ready handshake and shifted out LSB
//               first; a byte waiting in the holding register is started
//               straight out of STOP so back-to-back frames have no gap.
//   clk        in  clock
//   rst        in  synchronous active-high reset
//   tx_if      slave handshake (tx_data, tx_valid, tx_ready)
//   tx_serial  out serial line, registered, idles high
//   tx_busy    out frame in progress, registered
//   tx_done    out one-cycle pulse after the last stop-bit cycle
// Optional    : define UART_TX_PARITY_EN to add a parity bit (PARITY_ODD
//               selects odd parity); otherwise PARITY_ODD has no effect.
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = UART_DEFAULT_CLK_PER_BIT,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave tx_if,
  output logic     tx_serial,
  output logic     tx_busy,
  output logic     tx_done
);

  uart_state_e state_q, state_d;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        serial_q, serial_d;
  logic        busy_q;
  logic        done_q, done_d;
  logic        w_accept;
  logic        w_drain;
  logic        w_bit_end;
  logic        w_parity;

  // Ready depends only on the holding-register flag, never on tx_valid.
  assign tx_if.tx_ready = ~hold_full_q;
  assign w_accept       = tx_if.tx_valid & ~hold_full_q;

  // Counter is held at zero in IDLE so the start bit gets a full period.
  uart_baud_cnt #(
    .CLK_PER_BIT (CLK_PER_BIT)
  ) u_baud_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == S_IDLE),
    .bit_end_o (w_bit_end)
  );

`ifdef UART_TX_PARITY_EN
  assign w_parity = (^shift_q) ^ PARITY_ODD;
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = PARITY_ODD;
  assign w_parity            = 1'b1;
`endif

  // Accept needs an empty holder and drain needs a full one, so the two
  // never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (w_accept) begin
      hold_q      <= tx_if.tx_data;
      hold_full_q <= 1'b1;
    end else if (w_drain) begin
      hold_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      serial_q  <= serial_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    w_drain   = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          state_d = S_START;
          shift_d = hold_q;
          w_drain = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          done_d = 1'b1;
          if (hold_full_q) begin
            state_d = S_START;
            shift_d = hold_q;
            w_drain = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line value is decoded from the next state so tx_serial is a plain flop.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[bit_idx_d];
      S_PARITY: serial_d = w_parity;
      default:  serial_d = 1'b1;
    endcase
  end

  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule
`default_nettype wire
